// File: rtl/hamming_secded_encoder_stream.sv
// Streaming Hamming(12,8) encoder with a one-deep skid buffer.
// Each accepted byte becomes a 12-bit codeword. Positions 1,2,4,8 hold the
// even parity bits and the other positions hold the data bits, so a single
// flipped bit gives a syndrome equal to its position. An optional
// single-bit error can be injected after parity generation. The flag that
// records the injection travels with its word until that word is delivered.
module hamming_secded_encoder_stream #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             inj_en,
  input  logic [3:0]       inj_pos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:0]      out_code,
  output logic [CNT_W-1:0] word_cnt,
  output logic [7:0]       inj_cnt
);

  // Datapath: parity generation and error injection on the incoming byte
  logic [11:0] clean_code;
  logic [11:0] flip_mask;
  logic [11:0] enc_code;
  logic        inj_hit;

  assign clean_code[0]  = in_data[0] ^ in_data[1] ^ in_data[3] ^ in_data[4] ^ in_data[6];
  assign clean_code[1]  = in_data[0] ^ in_data[2] ^ in_data[3] ^ in_data[5] ^ in_data[6];
  assign clean_code[2]  = in_data[0];
  assign clean_code[3]  = in_data[1] ^ in_data[2] ^ in_data[3] ^ in_data[7];
  assign clean_code[4]  = in_data[1];
  assign clean_code[5]  = in_data[2];
  assign clean_code[6]  = in_data[3];
  assign clean_code[7]  = in_data[4] ^ in_data[5] ^ in_data[6] ^ in_data[7];
  assign clean_code[8]  = in_data[4];
  assign clean_code[9]  = in_data[5];
  assign clean_code[10] = in_data[6];
  assign clean_code[11] = in_data[7];

  // Positions 1..12 map to a single mask bit each.
  // Position 0 and positions 13..15 leave the mask empty.
  generate
    for (genvar gi = 0; gi < 12; gi++) begin : g_flip
      assign flip_mask[gi] = inj_en && (inj_pos == 4'(gi + 1));
    end
  endgenerate

  assign inj_hit  = |flip_mask;
  assign enc_code = clean_code ^ flip_mask;

  // Storage: output stage plus skid stage
  logic             out_valid_reg, out_valid_next;
  logic [11:0]      out_code_reg,  out_code_next;
  logic             out_inj_reg,   out_inj_next;
  logic             skid_valid_reg, skid_valid_next;
  logic [11:0]      skid_code_reg,  skid_code_next;
  logic             skid_inj_reg,   skid_inj_next;
  logic [CNT_W-1:0] word_cnt_reg,  word_cnt_next;
  logic [7:0]       inj_cnt_reg,   inj_cnt_next;
  logic             in_fire;
  logic             out_fire;

  // in_ready depends only on registered state and on reset.
  // It does not depend on out_ready.
  assign in_ready  = ~skid_valid_reg & ~rst;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_reg & out_ready;

  assign out_valid = out_valid_reg;
  assign out_code  = out_code_reg;
  assign word_cnt  = word_cnt_reg;
  assign inj_cnt   = inj_cnt_reg;

  // Next-state: move words between the stages and update the delivery counters
  always_comb begin
    out_valid_next  = out_valid_reg;
    out_code_next   = out_code_reg;
    out_inj_next    = out_inj_reg;
    skid_valid_next = skid_valid_reg;
    skid_code_next  = skid_code_reg;
    skid_inj_next   = skid_inj_reg;
    word_cnt_next   = word_cnt_reg;
    inj_cnt_next    = inj_cnt_reg;

    if (out_fire) begin
      word_cnt_next = word_cnt_reg + CNT_W'(1);
      if (out_inj_reg && (inj_cnt_reg != 8'hFF)) begin
        inj_cnt_next = inj_cnt_reg + 8'd1;
      end
      if (skid_valid_reg) begin
        // The older word held in the skid stage goes out next.
        // in_ready is low while the skid stage is full, so no new word arrives.
        out_code_next   = skid_code_reg;
        out_inj_next    = skid_inj_reg;
        skid_valid_next = 1'b0;
      end else if (in_fire) begin
        // Streaming case: the new word replaces the departing word.
        out_code_next = enc_code;
        out_inj_next  = inj_hit;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (!out_valid_reg) begin
      if (in_fire) begin
        out_valid_next = 1'b1;
        out_code_next  = enc_code;
        out_inj_next   = inj_hit;
      end
    end else if (in_fire) begin
      // The output stage is stalled, so the new word waits in the skid stage.
      skid_valid_next = 1'b1;
      skid_code_next  = enc_code;
      skid_inj_next   = inj_hit;
    end
  end

  // State registers with synchronous reset that discards any buffered words
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_code_reg   <= 12'h000;
      out_inj_reg    <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_code_reg  <= 12'h000;
      skid_inj_reg   <= 1'b0;
      word_cnt_reg   <= '0;
      inj_cnt_reg    <= 8'h00;
    end else begin
      out_valid_reg  <= out_valid_next;
      out_code_reg   <= out_code_next;
      out_inj_reg    <= out_inj_next;
      skid_valid_reg <= skid_valid_next;
      skid_code_reg  <= skid_code_next;
      skid_inj_reg   <= skid_inj_next;
      word_cnt_reg   <= word_cnt_next;
      inj_cnt_reg    <= inj_cnt_next;
    end
  end

endmodule

// File: tb/tb_hamming_secded_encoder_stream.sv
// Self-checking bench for hamming_secded_encoder_stream.
// The reference model builds each codeword from the general Hamming
// position rule and tracks buffered words in a queue of at most two.
// Directed literal checks pin the model; a random phase stresses handshakes.
module tb_hamming_secded_encoder_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        inj_en;
  logic [3:0]  inj_pos;
  logic        out_ready;

  logic        in_ready,  in_ready4;
  logic        out_valid, out_valid4;
  logic [11:0] out_code,  out_code4;
  logic [15:0] word_cnt;
  logic [3:0]  word_cnt4;
  logic [7:0]  inj_cnt,   inj_cnt4;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  typedef struct {
    logic [11:0] code;
    bit          inj;
  } ent_t;

  ent_t        q[$];
  int unsigned wc = 0;
  int          ic = 0;

  always #5 clk = ~clk;

  hamming_secded_encoder_stream #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .inj_en(inj_en), .inj_pos(inj_pos),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .word_cnt(word_cnt), .inj_cnt(inj_cnt)
  );

  hamming_secded_encoder_stream #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .inj_en(inj_en), .inj_pos(inj_pos),
    .out_valid(out_valid4), .out_ready(out_ready), .out_code(out_code4),
    .word_cnt(word_cnt4), .inj_cnt(inj_cnt4)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Hamming rule: data goes to the non-power-of-two positions, and the parity bit at 2^j covers every position with bit j set
  function automatic logic [11:0] encode(input logic [7:0] d);
    logic [11:0] c;
    int k;
    logic par;
    c = '0;
    k = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k++;
      end
    end
    for (int j = 0; j < 4; j++) begin
      par = 1'b0;
      for (int p = 1; p <= 12; p++) if ((p & (1 << j)) != 0) par ^= c[p-1];
      c[(1 << j) - 1] = par;
    end
    return c;
  endfunction

  function automatic int syndrome(input logic [11:0] c);
    int s;
    s = 0;
    for (int p = 1; p <= 12; p++) if (c[p-1]) s ^= p;
    return s;
  endfunction

  // Returns {corrected, data}
  function automatic logic [8:0] decode(input logic [11:0] c_in);
    logic [11:0] c;
    logic [7:0]  d;
    int s;
    int k;
    c = c_in;
    s = syndrome(c);
    if (s >= 1 && s <= 12) c[s-1] = ~c[s-1];
    k = 0;
    d = '0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p-1];
        k++;
      end
    end
    return {(s != 0), d};
  endfunction

  // Reference model: update the word queue and the counters on every rising edge
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      wc = 0;
      ic = 0;
    end else begin
      bit   ofire;
      bit   ifire;
      ent_t e;
      ofire = (q.size() > 0) && out_ready;
      ifire = in_valid && (q.size() < 2);
      if (ofire) begin
        wc++;
        if (q[0].inj && ic < 255) ic++;
        void'(q.pop_front());
      end
      if (ifire) begin
        e.code = encode(in_data);
        e.inj  = inj_en && (inj_pos >= 4'd1) && (inj_pos <= 4'd12);
        if (e.inj) e.code[inj_pos-1] = ~e.code[inj_pos-1];
        q.push_back(e);
      end
    end
  end

  // Compare the DUT outputs with the model on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",   {31'd0, in_ready},   {31'd0, (!rst && q.size() < 2)});
      check("out_valid",  {31'd0, out_valid},  {31'd0, (q.size() > 0)});
      check("out_valid4", {31'd0, out_valid4}, {31'd0, (q.size() > 0)});
      if (q.size() > 0) begin
        check("out_code",  {20'd0, out_code},  {20'd0, q[0].code});
        check("out_code4", {20'd0, out_code4}, {20'd0, q[0].code});
        if (!q[0].inj) check("clean_syndrome", syndrome(out_code), 0);
      end
      check("word_cnt",  {16'd0, word_cnt},  wc & 32'hFFFF);
      check("word_cnt4", {28'd0, word_cnt4}, wc & 32'hF);
      check("inj_cnt",   {24'd0, inj_cnt},   ic);
      check("inj_cnt4",  {24'd0, inj_cnt4},  ic);
    end
  end

  // Send one word with out_ready=1 and check the codeword presented one cycle later
  task automatic send_lit(input logic [7:0] d, input logic en, input logic [3:0] pos,
                          input logic [11:0] exp_code, input string nm, input bit chk_dec);
    logic [8:0] dec;
    in_valid = 1'b1;
    in_data  = d;
    inj_en   = en;
    inj_pos  = pos;
    @(posedge clk); #1;
    in_valid = 1'b0;
    inj_en   = 1'b0;
    @(negedge clk);
    check(nm, {20'd0, out_code}, {20'd0, exp_code});
    if (chk_dec) begin
      dec = decode(out_code);
      check("sweep_corrected", {31'd0, dec[8]}, 32'd1);
      check("sweep_data", {24'd0, dec[7:0]}, {24'd0, d});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset, with in_valid asserted during reset; the word must not be accepted
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; inj_en = 1'b0; inj_pos = 4'd0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_code", {20'd0, out_code}, 32'h000);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Encode table
    send_lit(8'h00, 1'b0, 4'd0, 12'h000, "enc_00", 1'b0);
    send_lit(8'h01, 1'b0, 4'd0, 12'h007, "enc_01", 1'b0);
    send_lit(8'h80, 1'b0, 4'd0, 12'h888, "enc_80", 1'b0);
    send_lit(8'hFF, 1'b0, 4'd0, 12'hF77, "enc_FF", 1'b0);
    check("enc_word_cnt", {16'd0, word_cnt}, 32'd4);

    // Backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h01;
    @(posedge clk); #1;
    in_data = 8'h80;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_hold_007", {20'd0, out_code}, 32'h007);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_still_007", {20'd0, out_code}, 32'h007);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_then_888", {20'd0, out_code}, 32'h888);
    check("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Injection
    send_lit(8'hFF, 1'b1, 4'd12, 12'h777, "inj_pos12", 1'b0);
    check("inj_cnt_one", {24'd0, inj_cnt}, 32'd1);
    send_lit(8'hFF, 1'b1, 4'd0, 12'hF77, "inj_pos0", 1'b0);
    check("inj_cnt_same", {24'd0, inj_cnt}, 32'd1);
    for (int p = 1; p <= 12; p++) begin
      logic [11:0] m;
      m = 12'h001 << (p - 1);
      send_lit(8'hFF, 1'b1, 4'(p), 12'hF77 ^ m, "inj_sweep", 1'b1);
    end

    // Reset mid-stream with two buffered words and an input asserted during reset
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h3C;
    @(posedge clk); #1;
    in_data = 8'hC3;
    @(posedge clk); #1;
    rst = 1'b1; in_data = 8'h55;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_word_cnt", {16'd0, word_cnt}, 32'd0);
    check("rst_mid_inj_cnt", {24'd0, inj_cnt}, 32'd0);
    repeat (5) @(posedge clk);
    #1;

    // Counter wrap at 4 bits after 17 transfers
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_data = 8'(i * 7);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("wrap_word_cnt4", {28'd0, word_cnt4}, 32'd1);
    check("wrap_word_cnt", {16'd0, word_cnt}, 32'd17);

    // Streaming 0..255 back to back
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("stream_word_cnt", {16'd0, word_cnt}, 32'd273);

    // Saturation of the injection counter
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom); inj_en = 1'b1; inj_pos = 4'($urandom_range(1, 12));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; inj_en = 1'b0;
    @(posedge clk); #1;
    check("sat_inj_cnt", {24'd0, inj_cnt}, 32'd255);

    // Random handshakes and injections
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      inj_en    = ($urandom_range(0, 3) == 0);
      inj_pos   = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
